// File: rtl/text_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the text-mode scanline fetch controller.
package text_fetch_ctrl_pkg;

    localparam int          CELL_W       = 8;
    localparam int          COLS_DEFAULT = 80;
    localparam logic [7:0]  CHR_FIRST    = 8'h20;
    localparam logic [7:0]  CHR_LAST     = 8'h9F;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        RUN
    } state_t;

endpackage

// File: rtl/text_fetch_ctrl_glyph_addr.sv
// Combinational character-code/glyph-row to character ROM address mapping.
module glyph_addr
    import text_fetch_ctrl_pkg::*;
(
    input  logic [7:0]  i_code,
    input  logic [3:0]  i_row,
    output logic [10:0] o_rom_addr
);

    logic [7:0]  w_code;
    logic [10:0] w_ofs;

    always_comb begin
        w_code = i_code;
        // Codes outside the printable range fall back to the blank glyph.
        if (i_code < CHR_FIRST || i_code > CHR_LAST) begin
            w_code = CHR_FIRST;
        end
        w_ofs      = {3'b000, w_code - CHR_FIRST};
        o_rom_addr = (w_ofs << 4) + {7'b0000000, i_row};
    end

endmodule

// File: rtl/text_fetch_ctrl.sv
// Scanline text fetch: reads codes, looks up glyph rows and serialises pixels.
module text_fetch_ctrl
    import text_fetch_ctrl_pkg::*;
#(
    parameter int COLS   = COLS_DEFAULT,
    parameter int TXT_AW = 12
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [3:0]        row,
    input  logic [TXT_AW-1:0] row_base,
    output logic [TXT_AW-1:0] txt_addr,
    output logic              txt_rd,
    input  logic [7:0]        txt_data,
    output logic [10:0]       rom_addr,
    input  logic [7:0]        rom_data,
    output logic              pixel,
    output logic              pixel_valid,
    output logic              line_done
);

    localparam int CW = $clog2(COLS + 1);

    state_t              r_state, w_state_nx;
    logic [2:0]          r_phase;
    logic [CW-1:0]       r_cell;
    logic [3:0]          r_row;
    logic [TXT_AW-1:0]   r_base;
    logic [CELL_W-1:0]   r_shift;
    logic [CELL_W-1:0]   r_next;
    logic [10:0]         w_rom_addr;
    logic [CW:0]         w_fetch_idx;
    logic                w_fetch_en;
    logic                w_have_fetch;
    logic                w_last_cell;
    logic                w_load;
    logic                w_active;

    glyph_addr u_glyph_addr (
        .i_code     (txt_data),
        .i_row      (r_row),
        .o_rom_addr (w_rom_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_active     = (r_state != IDLE);
        w_last_cell  = (r_cell == CW'(COLS - 1));
        // r_cell is the cell being shifted out; the next fetch targets the one after.
        w_fetch_idx  = (r_state == PREFETCH) ? (CW+1)'(1) : ({1'b0, r_cell} + (CW+1)'(2));
        w_fetch_en   = (w_fetch_idx < (CW+1)'(COLS));
        w_have_fetch = (r_state == PREFETCH) || (({1'b0, r_cell} + (CW+1)'(1)) < (CW+1)'(COLS));
        case (r_state)
            PREFETCH: if (r_phase == 3'd7) w_state_nx = RUN;
            RUN:      if (r_phase == 3'd7 && w_last_cell) w_state_nx = IDLE;
            default:  w_state_nx = r_state;
        endcase
        if (line_start) begin
            w_state_nx = PREFETCH;
        end
        w_load = (r_phase == 3'd7) && (w_state_nx == RUN) && !line_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= '0;
            r_cell      <= '0;
            r_row       <= '0;
            r_base      <= '0;
            r_shift     <= '0;
            r_next      <= '0;
            txt_addr    <= '0;
            txt_rd      <= 1'b0;
            rom_addr    <= '0;
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
            line_done   <= 1'b0;
        end else if (line_start) begin
            r_row       <= row;
            r_base      <= row_base;
            r_phase     <= '0;
            r_cell      <= '0;
            txt_addr    <= row_base;
            txt_rd      <= 1'b1;
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
            line_done   <= 1'b0;
        end else begin
            txt_rd    <= 1'b0;
            line_done <= 1'b0;
            if (w_active) begin
                r_phase <= r_phase + 3'd1;
            end
            if (w_active && w_have_fetch && r_phase == 3'd1) begin
                rom_addr <= w_rom_addr;
            end
            if (w_active && w_have_fetch && r_phase == 3'd3) begin
                r_next <= rom_data;
            end
            if (r_state == RUN && r_phase == 3'd6 && w_last_cell) begin
                line_done <= 1'b1;
            end

            if (w_load) begin
                pixel       <= r_next[CELL_W-1];
                r_shift     <= {r_next[CELL_W-2:0], 1'b0};
                pixel_valid <= 1'b1;
                if (r_state == RUN) begin
                    r_cell <= r_cell + CW'(1);
                end
                if (w_fetch_en) begin
                    txt_addr <= r_base + TXT_AW'(w_fetch_idx);
                    txt_rd   <= 1'b1;
                end
            end else if (r_state == RUN && r_phase != 3'd7) begin
                pixel       <= r_shift[CELL_W-1];
                r_shift     <= {r_shift[CELL_W-2:0], 1'b0};
                pixel_valid <= 1'b1;
            end else begin
                pixel       <= 1'b0;
                pixel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Self-checking bench for text_fetch_ctrl with RAM/ROM models and a per-line reference.
module tb_text_fetch_ctrl;

    localparam int COLS = 80;
    localparam int AW   = 12;
    localparam int NPIX = COLS * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          line_start = 1'b0;
    logic [3:0]    row = '0;
    logic [AW-1:0] row_base = '0;
    logic [AW-1:0] txt_addr;
    logic          txt_rd;
    logic [7:0]    txt_data = '0;
    logic [10:0]   rom_addr;
    logic [7:0]    rom_data = '0;
    logic          pixel, pixel_valid, line_done;

    logic [7:0] ram_m [0:(1<<AW)-1];
    logic [7:0] rom_m [0:2047];

    int errors = 0;
    int checks = 0;

    int          nread, nvalid, first_k, done_k;
    logic [AW-1:0] first_rd, last_rd;
    logic [10:0] obs_rom [0:COLS-1];
    logic [7:0]  obs_cell0;
    logic        s_done, s_valid;

    text_fetch_ctrl #(.COLS(COLS), .TXT_AW(AW)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .row(row), .row_base(row_base),
        .txt_addr(txt_addr), .txt_rd(txt_rd), .txt_data(txt_data),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel(pixel), .pixel_valid(pixel_valid), .line_done(line_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (txt_rd) txt_data <= ram_m[txt_addr];
        rom_data <= rom_m[rom_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [10:0] gmap(input logic [7:0] code, input logic [3:0] r);
        int c;
        c = (code < 8'h20 || code > 8'h9F) ? 32 : int'(code);
        return 11'((c - 32) * 16 + int'(r));
    endfunction

    task automatic fill_random();
        for (int i = 0; i < (1 << AW); i++) ram_m[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) rom_m[i] = 8'($urandom);
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input logic [3:0] r);
        @(posedge clk); #1;
        line_start = 1'b1; row = r; row_base = base;
        @(negedge clk);
        s_done  = line_done;
        s_valid = pixel_valid;
        @(posedge clk); #1;
        line_start = 1'b0; row = 4'($urandom); row_base = AW'($urandom);
    endtask

    // Checks cycles 1..max_k after a line_start against the expected scanline.
    task automatic run_line(input logic [AW-1:0] base, input logic [3:0] r, input int max_k);
        int j, c;
        logic exp_v, exp_p, exp_d, exp_rd;
        logic [AW-1:0] a;
        logic [10:0] exp_ra;
        nread = 0; nvalid = 0; first_k = -1; done_k = -1; obs_cell0 = '0;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            exp_v = (k >= 9 && k < 9 + NPIX);
            exp_p = 1'b0;
            if (exp_v) begin
                j = k - 9;
                a = base + AW'(j / 8);
                exp_p = rom_m[gmap(ram_m[a], r)][7 - (j % 8)];
            end
            exp_d  = (k == 8 + NPIX);
            exp_rd = ((k - 1) % 8 == 0) && ((k - 1) / 8 < COLS);
            if (pixel_valid) nvalid++;
            if (pixel_valid && first_k < 0) first_k = k;
            if (line_done) done_k = k;
            if (k >= 9 && k < 17) obs_cell0[16 - k] = pixel;
            checks++;
            if (pixel_valid !== exp_v) begin
                errors++;
                $display("FAIL pixel_valid k=%0d got=%b exp=%b", k, pixel_valid, exp_v);
            end
            checks++;
            if (pixel !== exp_p) begin
                errors++;
                $display("FAIL pixel k=%0d got=%b exp=%b", k, pixel, exp_p);
            end
            checks++;
            if (line_done !== exp_d) begin
                errors++;
                $display("FAIL line_done k=%0d got=%b exp=%b", k, line_done, exp_d);
            end
            checks++;
            if (txt_rd !== exp_rd) begin
                errors++;
                $display("FAIL txt_rd k=%0d got=%b exp=%b", k, txt_rd, exp_rd);
            end
            if (txt_rd) begin
                if (nread == 0) first_rd = txt_addr;
                last_rd = txt_addr;
                nread++;
            end
            if (exp_rd) begin
                a = base + AW'((k - 1) / 8);
                checks++;
                if (txt_addr !== a) begin
                    errors++;
                    $display("FAIL txt_addr k=%0d got=%h exp=%h", k, txt_addr, a);
                end
            end
            if (k >= 3 && (k - 3) % 8 == 0 && (k - 3) / 8 < COLS) begin
                c = (k - 3) / 8;
                a = base + AW'(c);
                exp_ra = gmap(ram_m[a], r);
                obs_rom[c] = rom_addr;
                checks++;
                if (rom_addr !== exp_ra) begin
                    errors++;
                    $display("FAIL rom_addr k=%0d got=%h exp=%h", k, rom_addr, exp_ra);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; line_start = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; line_start = 1'b0;
        @(negedge clk);
        checks++;
        if ({txt_rd, pixel, pixel_valid, line_done} !== 4'b0000 || txt_addr !== '0 || rom_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b pix=%b v=%b d=%b ta=%h ra=%h exp all 0",
                     txt_rd, pixel, pixel_valid, line_done, txt_addr, rom_addr);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (txt_rd !== 1'b0 || pixel_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got rd=%b v=%b exp 0 0", txt_rd, pixel_valid);
        end
    endtask

    task automatic test_basic_line();
        for (int i = 0; i < (1 << AW); i++) ram_m[i] = 8'h41;
        rom_m[11'h213] = 8'hA5;
        pulse_start(12'h050, 4'd3);
        run_line(12'h050, 4'd3, NPIX + 12);
        checks++;
        if (first_k !== 9) begin
            errors++; $display("FAIL first_valid_latency got=%0d exp=9", first_k);
        end
        checks++;
        if (nvalid !== NPIX) begin
            errors++; $display("FAIL valid_count got=%0d exp=%0d", nvalid, NPIX);
        end
        checks++;
        if (done_k !== 8 + NPIX) begin
            errors++; $display("FAIL line_done_cycle got=%0d exp=%0d", done_k, 8 + NPIX);
        end
        checks++;
        if (obs_cell0 !== 8'hA5) begin
            errors++; $display("FAIL cell0_pattern got=%h exp=a5", obs_cell0);
        end
    endtask

    task automatic test_glyph_map();
        logic [7:0] codes [0:3];
        codes[0] = 8'h00; codes[1] = 8'h1F; codes[2] = 8'hA0; codes[3] = 8'hFF;
        fill_random();
        for (int i = 0; i < 4; i++) ram_m[12'h200 + i] = codes[i];
        pulse_start(12'h200, 4'd5);
        run_line(12'h200, 4'd5, NPIX + 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_rom[i] !== 11'h005) begin
                errors++; $display("FAIL out_of_range_code %h got=%h exp=005", codes[i], obs_rom[i]);
            end
        end
        ram_m[12'h300] = 8'h9F;
        pulse_start(12'h300, 4'd15);
        run_line(12'h300, 4'd15, NPIX + 4);
        checks++;
        if (obs_rom[0] !== 11'h7FF) begin
            errors++; $display("FAIL code_9f_row15 got=%h exp=7ff", obs_rom[0]);
        end
    endtask

    task automatic test_addr_trace();
        fill_random();
        pulse_start(12'h0F0, 4'($urandom));
        run_line(12'h0F0, row, 0);
        pulse_start(12'h0F0, 4'd7);
        run_line(12'h0F0, 4'd7, NPIX + 20);
        checks++;
        if (nread !== COLS || first_rd !== 12'h0F0 || last_rd !== 12'h13F) begin
            errors++;
            $display("FAIL addr_trace reads=%0d first=%h last=%h exp 80 0f0 13f", nread, first_rd, last_rd);
        end
    endtask

    task automatic test_random_lines();
        logic [AW-1:0] b;
        logic [3:0] r;
        for (int n = 0; n < 4; n++) begin
            fill_random();
            b = (n == 0) ? 12'hFE0 : AW'($urandom);
            r = 4'($urandom);
            pulse_start(b, r);
            run_line(b, r, NPIX + 8 + $urandom_range(1, 6));
        end
    endtask

    task automatic test_abort();
        fill_random();
        pulse_start(12'h123, 4'd9);
        run_line(12'h123, 4'd9, 9 + 40 * 8);
        pulse_start(12'h456, 4'd2);
        checks++;
        if (s_done !== 1'b0) begin
            errors++; $display("FAIL abort_no_done got=%b exp=0", s_done);
        end
        run_line(12'h456, 4'd2, NPIX + 10);
        checks++;
        if (done_k !== 8 + NPIX) begin
            errors++; $display("FAIL abort_restart_done got=%0d exp=%0d", done_k, 8 + NPIX);
        end
    endtask

    task automatic test_coincident();
        fill_random();
        pulse_start(12'h010, 4'd1);
        run_line(12'h010, 4'd1, 7 + NPIX);
        pulse_start(12'h020, 4'd4);
        checks++;
        if (s_done !== 1'b1 || s_valid !== 1'b1) begin
            errors++; $display("FAIL coincident_final got done=%b valid=%b exp 1 1", s_done, s_valid);
        end
        run_line(12'h020, 4'd4, NPIX + 10);
    endtask

    task automatic test_reset_mid();
        fill_random();
        pulse_start(12'h777, 4'd6);
        run_line(12'h777, 4'd6, 9 + 10 * 8);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({txt_rd, pixel, pixel_valid, line_done} !== 4'b0000 || txt_addr !== '0 || rom_addr !== '0) begin
            errors++;
            $display("FAIL midline_reset got rd=%b pix=%b v=%b d=%b ta=%h ra=%h exp all 0",
                     txt_rd, pixel, pixel_valid, line_done, txt_addr, rom_addr);
        end
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (pixel_valid || txt_rd) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin
            errors++; $display("FAIL no_resume got=%0d active cycles exp=0", nvalid);
        end
        pulse_start(12'h777, 4'd6);
        run_line(12'h777, 4'd6, NPIX + 10);
    endtask

    initial begin
        fill_random();
        test_reset();
        test_basic_line();
        test_glyph_map();
        test_addr_trace();
        test_random_lines();
        test_abort();
        test_coincident();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
